// File: rtl/cpu_types_pkg.sv
// Shared CPU types: machine word and register-file clear-engine states.
// Imported by register_file_mp and register_file_clear_fsm.
package cpu_types_pkg;

    typedef logic [31:0] word_t;

    typedef enum logic [1:0] {
        RF_IDLE  = 2'd0,
        RF_CLEAR = 2'd1,
        RF_DONE  = 2'd2
    } rf_state_t;

endpackage

// File: rtl/register_file_clear_fsm.sv
// Sequential clear engine: walks the register index from 0 to NREG-1,
// issuing one clear strobe per cycle, then pulses done for a single cycle.
module register_file_clear_fsm
    import cpu_types_pkg::*;
#(
    parameter int NREG = 32,
    localparam int AW = $clog2(NREG)
) (
    input  logic          clk,
    input  logic          nRST,
    input  logic          i_clr_req,
    output logic          o_clr_busy,
    output logic          o_clr_done,
    output logic          o_clr_stb,
    output logic [AW-1:0] o_clr_idx
);

    localparam logic [AW-1:0] LAST = AW'(NREG - 1);

    rf_state_t     r_state;
    logic [AW-1:0] r_ptr;

    always_ff @(posedge clk or negedge nRST) begin
        if (!nRST) begin
            r_state <= RF_IDLE;
            r_ptr   <= '0;
        end else begin
            unique case (r_state)
                RF_IDLE: begin
                    if (i_clr_req) r_state <= RF_CLEAR;
                end
                RF_CLEAR: begin
                    if (r_ptr == LAST) begin
                        r_ptr   <= '0;
                        r_state <= RF_DONE;
                    end else begin
                        r_ptr <= r_ptr + 1'b1;
                    end
                end
                RF_DONE: r_state <= RF_IDLE;
                default: r_state <= RF_IDLE;
            endcase
        end
    end

    assign o_clr_busy = (r_state != RF_IDLE);
    assign o_clr_done = (r_state == RF_DONE);
    assign o_clr_stb  = (r_state == RF_CLEAR);
    assign o_clr_idx  = r_ptr;

endmodule

// File: rtl/register_file_mp.sv
// Multi-port register file with busy scoreboard and sequential clear engine.
// Optional same-cycle write-to-read forwarding when RF_BYPASS_EN is defined.
module register_file_mp
    import cpu_types_pkg::*;
#(
    parameter int DW       = 32,
    parameter int NREG     = 32,
    parameter int NRD      = 2,
    parameter int NWR      = 2,
    parameter int ZERO_REG = 1,
    localparam int AW = $clog2(NREG)
) (
    input  logic                    clk,
    input  logic                    nRST,
    input  logic [NRD-1:0][AW-1:0]  rsel,
    output logic [NRD-1:0][DW-1:0]  rdat,
    output logic [NRD-1:0]          rbusy,
    input  logic [NWR-1:0]          wen,
    input  logic [NWR-1:0][AW-1:0]  wsel,
    input  logic [NWR-1:0][DW-1:0]  wdat,
    input  logic                    rsv_en,
    input  logic [AW-1:0]           rsv_sel,
    input  logic                    clr_req,
    output logic                    clr_busy,
    output logic                    clr_done
);

    logic [DW-1:0]   r_regs [NREG];
    logic [NREG-1:0] r_busy;

    logic            w_clr_stb;
    logic [AW-1:0]   w_clr_idx;
    logic [NWR-1:0]  w_wr_ok;
    logic            w_rsv_ok;
    logic [NRD-1:0]  w_rzero;

    register_file_clear_fsm #(
        .NREG (NREG)
    ) u_clr_fsm (
        .clk        (clk),
        .nRST       (nRST),
        .i_clr_req  (clr_req),
        .o_clr_busy (clr_busy),
        .o_clr_done (clr_done),
        .o_clr_stb  (w_clr_stb),
        .o_clr_idx  (w_clr_idx)
    );

    // Hard-wired zero register swallows writes and reservations.
    always_comb begin
        for (int j = 0; j < NWR; j++) begin
            w_wr_ok[j] = wen[j] && !clr_busy
                      && !((ZERO_REG != 0) && (wsel[j] == '0))
                      && (int'(wsel[j]) < NREG);
        end
        w_rsv_ok = rsv_en && !clr_busy
                && !((ZERO_REG != 0) && (rsv_sel == '0))
                && (int'(rsv_sel) < NREG);
        for (int i = 0; i < NRD; i++) begin
            w_rzero[i] = (ZERO_REG != 0) && (rsel[i] == '0);
        end
    end

    // Ascending port loop: the last (highest) writer wins; reserve wins over write.
    always_ff @(posedge clk or negedge nRST) begin
        if (!nRST) begin
            for (int k = 0; k < NREG; k++) begin
                r_regs[k] <= '0;
            end
            r_busy <= '0;
        end else if (w_clr_stb) begin
            r_regs[w_clr_idx] <= '0;
            r_busy[w_clr_idx] <= 1'b0;
        end else begin
            for (int j = 0; j < NWR; j++) begin
                if (w_wr_ok[j]) begin
                    r_regs[wsel[j]] <= wdat[j];
                    r_busy[wsel[j]] <= 1'b0;
                end
            end
            if (w_rsv_ok) r_busy[rsv_sel] <= 1'b1;
        end
    end

    always_comb begin
        for (int i = 0; i < NRD; i++) begin
            rdat[i]  = w_rzero[i] ? '0 : r_regs[rsel[i]];
            rbusy[i] = clr_busy | (!w_rzero[i] & r_busy[rsel[i]]);
`ifdef RF_BYPASS_EN
            if (!clr_busy && !w_rzero[i]) begin
                for (int j = 0; j < NWR; j++) begin
                    if (wen[j] && (wsel[j] == rsel[i])) begin
                        rdat[i]  = wdat[j];
                        rbusy[i] = 1'b0;
                    end
                end
            end
`endif
        end
    end

endmodule

// File: tb/tb_register_file_mp.sv
// Directed bench for register_file_mp (32x32, 2 read, 2 write, zero reg).
// Forwarding expectations follow RF_BYPASS_EN.
module tb_register_file_mp;

    logic             clk;
    logic             nRST;
    logic [1:0][4:0]  rsel;
    logic [1:0][31:0] rdat;
    logic [1:0]       rbusy;
    logic [1:0]       wen;
    logic [1:0][4:0]  wsel;
    logic [1:0][31:0] wdat;
    logic             rsv_en;
    logic [4:0]       rsv_sel;
    logic             clr_req;
    logic             clr_busy;
    logic             clr_done;

    int total;
    int bad;
    int n;

    register_file_mp #(
        .DW       (32),
        .NREG     (32),
        .NRD      (2),
        .NWR      (2),
        .ZERO_REG (1)
    ) dut (
        .clk      (clk),
        .nRST     (nRST),
        .rsel     (rsel),
        .rdat     (rdat),
        .rbusy    (rbusy),
        .wen      (wen),
        .wsel     (wsel),
        .wdat     (wdat),
        .rsv_en   (rsv_en),
        .rsv_sel  (rsv_sel),
        .clr_req  (clr_req),
        .clr_busy (clr_busy),
        .clr_done (clr_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_in();
        wen     = '0;
        rsv_en  = 1'b0;
        clr_req = 1'b0;
    endtask

    task automatic wr1(input logic [4:0] a, input logic [31:0] d);
        wen[0]  = 1'b1;
        wsel[0] = a;
        wdat[0] = d;
        tick();
        wen[0]  = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        for (int i = 0; i < 32; i++) begin
            rsel[0] = 5'(i);
            rsel[1] = 5'(31 - i);
            #1;
            chk({tag, "_d0"}, rdat[0], 32'h0);
            chk({tag, "_d1"}, rdat[1], 32'h0);
            chk({tag, "_b"}, {30'h0, rbusy}, 32'h0);
        end
    endtask

    task automatic fill_regs();
        for (int i = 1; i < 32; i++) wr1(5'(i), 32'(i));
    endtask

    initial begin
        total = 0;
        bad   = 0;
        nRST  = 1'b0;
        rsel  = '0;
        wsel  = '0;
        wdat  = '0;
        rsv_sel = '0;
        idle_in();
        tick();
        tick();
        nRST = 1'b1;
        tick();

        // reset state
        check_all_zero("rst");
        chk("rst_cbusy", {31'h0, clr_busy}, 32'h0);
        chk("rst_cdone", {31'h0, clr_done}, 32'h0);

        // same-address dual write: port 1 wins
        wen  = 2'b11;
        wsel[0] = 5'd5; wdat[0] = 32'hDEAD0001;
        wsel[1] = 5'd5; wdat[1] = 32'hBEEF0002;
        tick();
        wen = '0;
        rsel[0] = 5'd5;
        rsel[1] = 5'd5;
        #1;
        chk("prio_d0", rdat[0], 32'hBEEF0002);
        chk("prio_d1", rdat[1], 32'hBEEF0002);

        // reserve, write clears busy, reserve+write same cycle stays busy
        rsv_en = 1'b1; rsv_sel = 5'd7;
        tick();
        rsv_en = 1'b0;
        rsel[0] = 5'd7;
        rsel[1] = 5'd5;
        #1;
        chk("rsv_b0", {31'h0, rbusy[0]}, 32'h1);
        chk("rsv_b1", {31'h0, rbusy[1]}, 32'h0);
        wr1(5'd7, 32'h12);
        chk("wr_clr_b", {31'h0, rbusy[0]}, 32'h0);
        chk("wr_clr_d", rdat[0], 32'h12);
        rsv_en = 1'b1; rsv_sel = 5'd7;
        wen[1] = 1'b1; wsel[1] = 5'd7; wdat[1] = 32'h34;
        tick();
        idle_in();
        chk("rsvwr_b", {31'h0, rbusy[0]}, 32'h1);
        chk("rsvwr_d", rdat[0], 32'h34);

        // zero register
        rsel[0] = 5'd0;
        wen[0] = 1'b1; wsel[0] = 5'd0; wdat[0] = 32'hFFFFFFFF;
        rsv_en = 1'b1; rsv_sel = 5'd0;
        #1;
        chk("r0_same_d", rdat[0], 32'h0);
        tick();
        idle_in();
        chk("r0_d", rdat[0], 32'h0);
        chk("r0_b", {31'h0, rbusy[0]}, 32'h0);

        // forwarding (or not) of a same-cycle write
        wr1(5'd3, 32'h11);
        rsv_en = 1'b1; rsv_sel = 5'd3;
        tick();
        rsv_en = 1'b0;
        rsel[1] = 5'd3;
        wen[1] = 1'b1; wsel[1] = 5'd3; wdat[1] = 32'hA5;
        #1;
`ifdef RF_BYPASS_EN
        chk("byp_d", rdat[1], 32'hA5);
        chk("byp_b", {31'h0, rbusy[1]}, 32'h0);
`else
        chk("nobyp_d", rdat[1], 32'h11);
        chk("nobyp_b", {31'h0, rbusy[1]}, 32'h1);
`endif
        tick();
        wen = '0;
        #1;
        chk("byp_after", rdat[1], 32'hA5);

        // sequential clear with writes held during it
        fill_regs();
        rsel[0] = 5'd31;
        #1;
        chk("fill_r31", rdat[0], 32'd31);
        rsv_en = 1'b1; rsv_sel = 5'd9;
        tick();
        rsv_en = 1'b0;
        clr_req = 1'b1;
        tick();
        n = 1;
        clr_req = 1'b1;
        wen[0] = 1'b1; wsel[0] = 5'd31; wdat[0] = 32'hCAFE;
        rsel[1] = 5'd2;
        #1;
        chk("clr_busy", {31'h0, clr_busy}, 32'h1);
        chk("clr_rb", {30'h0, rbusy}, 32'h3);
        chk("clr_part", rdat[0], 32'd31);
        while (!clr_done && n < 100) begin
            tick();
            n++;
        end
        chk("clr_lat", 32'(n), 32'd33);
        chk("done_busy", {31'h0, clr_busy}, 32'h1);
        idle_in();
        tick();
        chk("done_pulse", {31'h0, clr_done}, 32'h0);
        chk("clr_idle", {31'h0, clr_busy}, 32'h0);
        check_all_zero("clr");

        // reset aborts a clear in progress
        fill_regs();
        clr_req = 1'b1;
        tick();
        clr_req = 1'b0;
        for (int i = 0; i < 9; i++) tick();
        rsel[0] = 5'd20;
        #1;
        chk("abort_pre", rdat[0], 32'd20);
        nRST = 1'b0;
        #1;
        chk("abort_busy", {31'h0, clr_busy}, 32'h0);
        chk("abort_done", {31'h0, clr_done}, 32'h0);
        tick();
        nRST = 1'b1;
        tick();
        chk("abort_idle", {31'h0, clr_busy}, 32'h0);
        check_all_zero("abort");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
